// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt sequencer: FSM states,
// cause encodings and the default handler vectors.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TAKE    = 2'd1,
    SERVICE = 2'd2,
    RETURN  = 2'd3
  } irq_state_t;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_INT  = 2'b01;
  localparam logic [1:0] CAUSE_NMI  = 2'b10;

  localparam logic [31:0] DEF_INT_VECTOR = 32'h0000_0080;
  localparam logic [31:0] DEF_NMI_VECTOR = 32'h0000_0100;

endpackage

// File: rtl/irq_sequencer_if.sv
// Controller-side bundle of interrupt lines, PC and redirect outputs.
// master = Controller/source side, slave = irq_sequencer.
interface irq_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             INT;
  logic             NMI;
  logic             INTD;
  logic             atBoundary;
  logic             eret;
  logic [WIDTH-1:0] pc;
  logic             isInterrupted;
  logic             INA;
  logic [WIDTH-1:0] vectorPC;
  logic [WIDTH-1:0] epc;
  logic [1:0]       cause;

  modport master (
    output INT, NMI, INTD, atBoundary, eret, pc,
    input  isInterrupted, INA, vectorPC, epc, cause
  );

  modport slave (
    input  INT, NMI, INTD, atBoundary, eret, pc,
    output isInterrupted, INA, vectorPC, epc, cause
  );
endinterface

// File: rtl/irq_edge_latch.sv
// Rising-edge detector with a sticky pending flag; a new edge beats a
// same-cycle clear. Register reset to 0, so input high at release is one edge.
module irq_edge_latch (
  input  logic Clk,
  input  logic Rst_n,
  input  logic i_in,
  input  logic i_clr,
  output logic o_pend
);
  logic r_q;
  logic r_pend;
  logic w_set;

  assign w_set  = i_in & ~r_q;
  assign o_pend = r_pend;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_q    <= 1'b0;
      r_pend <= 1'b0;
    end else begin
      r_q    <= i_in;
      r_pend <= w_set | (r_pend & ~i_clr);
    end
  end
endmodule

// File: rtl/irq_sequencer.sv
// Interrupt sequencer beside the multi-cycle MIPS Controller: NMI over INT,
// redirect at instruction boundary, return on eret. Macro INT_EDGE_EN latches INT edges.
import irq_pkg::*;

module irq_sequencer #(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] INT_VECTOR = WIDTH'(DEF_INT_VECTOR),
  parameter logic [WIDTH-1:0] NMI_VECTOR = WIDTH'(DEF_NMI_VECTOR)
) (
  input logic            Clk,
  input logic            Rst_n,
  irq_sequencer_if.slave bus
);
  irq_state_t       r_state;
  irq_state_t       w_next;
  logic [WIDTH-1:0] r_epc;
  logic [1:0]       r_cause;
  logic             w_nmi_pend;
  logic             w_nmi_clr;
  logic             w_int_req;
  logic             w_accept;

  // Pending flags drop at the end of the TAKE cycle that serviced them.
  assign w_nmi_clr = (r_state == TAKE) && (r_cause == CAUSE_NMI);

  irq_edge_latch u_nmi_latch (
    .Clk    (Clk),
    .Rst_n  (Rst_n),
    .i_in   (bus.NMI),
    .i_clr  (w_nmi_clr),
    .o_pend (w_nmi_pend)
  );

`ifdef INT_EDGE_EN
  logic w_int_clr;
  assign w_int_clr = (r_state == TAKE) && (r_cause == CAUSE_INT);

  irq_edge_latch u_int_latch (
    .Clk    (Clk),
    .Rst_n  (Rst_n),
    .i_in   (bus.INT),
    .i_clr  (w_int_clr),
    .o_pend (w_int_req)
  );
`else
  assign w_int_req = bus.INT;
`endif

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.atBoundary && (w_nmi_pend || (w_int_req && !bus.INTD))) begin
          w_accept = 1'b1;
          w_next   = TAKE;
        end
      end
      TAKE:    w_next = SERVICE;
      SERVICE: if (bus.eret) w_next = RETURN;
      RETURN:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    bus.isInterrupted = 1'b0;
    bus.INA           = 1'b0;
    bus.vectorPC      = '0;
    case (r_state)
      TAKE: begin
        bus.isInterrupted = 1'b1;
        bus.INA           = 1'b1;
        bus.vectorPC      = (r_cause == CAUSE_NMI) ? NMI_VECTOR : INT_VECTOR;
      end
      RETURN: begin
        bus.isInterrupted = 1'b1;
        bus.vectorPC      = r_epc;
      end
      default: ;
    endcase
  end

  assign bus.epc   = r_epc;
  assign bus.cause = r_cause;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= IDLE;
      r_epc   <= '0;
      r_cause <= CAUSE_NONE;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_epc   <= bus.pc;
        r_cause <= w_nmi_pend ? CAUSE_NMI : CAUSE_INT;
      end else if (r_state == RETURN) begin
        r_cause <= CAUSE_NONE;
      end
    end
  end
endmodule
